// File: rtl/seg7_pkg.sv
// Shared font table, polarity helpers and prescaler math for the 7-segment scanner.
package seg7_pkg;

   // Active-high g..a patterns for hex digits 0-F.
   localparam logic [6:0] FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [7:0] seg_off(input bit active_low);
      return active_low ? 8'hFF : 8'h00;
   endfunction

   function automatic logic an_off(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned scan_hz);
      return clk_hz / scan_hz;
   endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational hex nibble to active-high g..a segment pattern.
module seg7_font
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] pattern_o
);

   assign pattern_o = FONT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment scanner with frame snapshot, gap and leading-zero blanking.
// Optional anode PWM dimming is enabled by defining SEG7_PWM_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter int unsigned SCAN_HZ        = 1000,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] digits,
   input  logic [DIGITS-1:0]   digit_en,
   input  logic [DIGITS-1:0]   dp,
   input  logic                blank_lz,
`ifdef SEG7_PWM_EN
   input  logic [3:0]          brightness,
`endif
   output logic [7:0]          seg,
   output logic [DIGITS-1:0]   an,
   output logic                frame_start
);

   localparam int unsigned       Div      = calc_div(CLK_HZ, SCAN_HZ);
   localparam int unsigned       CntW     = (Div > 1) ? $clog2(Div) : 1;
   localparam int unsigned       IdxW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CntW-1:0]   CntMax   = CntW'(Div - 1);
   localparam logic [CntW-1:0]   GapEnd   = CntW'(GAP_CYCLES);
   localparam logic [IdxW-1:0]   IdxMax   = IdxW'(DIGITS - 1);
   localparam logic [7:0]        SegOff   = seg_off(SEG_ACTIVE_LOW);
   localparam logic              AnOffBit = an_off(AN_ACTIVE_LOW);
   localparam logic [DIGITS-1:0] AnOff    = {DIGITS{AnOffBit}};

   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [DIGITS-1:0]   en_q, en_d;
   logic [DIGITS-1:0]   dp_q, dp_d;
   logic                blank_q, blank_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                fs_q, fs_d;
   logic                snap, show, lit, pwm_on, zero_run;
   logic [DIGITS-1:0]   lz_blank;
   logic [3:0]          nib_sel;
   logic                en_sel, dp_sel, lz_sel;
   logic [6:0]          font_pat;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CntMax) begin
         cnt_d = '0;
         idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end
   end

   // Outputs are computed from the next shadow so the first slot of a frame uses fresh data.
   assign snap     = (cnt_q == '0) && (idx_q == '0);
   assign digits_d = snap ? digits   : digits_q;
   assign en_d     = snap ? digit_en : en_q;
   assign dp_d     = snap ? dp       : dp_q;
   assign blank_d  = snap ? blank_lz : blank_q;
   assign fs_d     = snap;
   assign show     = (cnt_q >= GapEnd);

`ifdef SEG7_PWM_EN
   localparam int unsigned SubW = (CntW > 4) ? CntW : 4;
   logic [3:0]      bright_q, bright_d;
   logic [SubW-1:0] sub;

   assign bright_d = snap ? brightness : bright_q;
   assign sub      = SubW'(cnt_q) - SubW'(GAP_CYCLES);
   assign pwm_on   = (sub[3:0] <= bright_d);

   always_ff @(posedge clk) begin
      if (rst) bright_q <= '0;
      else     bright_q <= bright_d;
   end
`else
   assign pwm_on = 1'b1;
`endif

   // Walk down from the most significant digit while every nibble so far is zero.
   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         zero_run    = zero_run && (digits_d[4*i +: 4] == 4'h0);
         lz_blank[i] = blank_d && zero_run;
      end
   end

   always_comb begin
      nib_sel = '0;
      en_sel  = 1'b0;
      dp_sel  = 1'b0;
      lz_sel  = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            nib_sel = digits_d[4*i +: 4];
            en_sel  = en_d[i];
            dp_sel  = dp_d[i];
            lz_sel  = lz_blank[i];
         end
      end
   end

   seg7_font u_font (
      .nibble_i  (nib_sel),
      .pattern_o (font_pat)
   );

   assign lit = show && en_sel && !lz_sel;

   always_comb begin
      seg_d = SegOff;
      an_d  = AnOff;
      if (lit) begin
         seg_d = SEG_ACTIVE_LOW ? ~{dp_sel, font_pat} : {dp_sel, font_pat};
         for (int i = 0; i < int'(DIGITS); i++) begin
            if ((idx_q == IdxW'(i)) && pwm_on) an_d[i] = ~AnOffBit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         digits_q <= '0;
         en_q     <= '0;
         dp_q     <= '0;
         blank_q  <= 1'b0;
         seg_q    <= SegOff;
         an_q     <= AnOff;
         fs_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         digits_q <= digits_d;
         en_q     <= en_d;
         dp_q     <= dp_d;
         blank_q  <= blank_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         fs_q     <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = fs_q;

endmodule
